// File: rtl/act_stream_ctrl_pkg.sv
// Shared definitions for the activation streamer: FSM states and SRAM timing.
package act_stream_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int XMEM_RD_LAT = 1;
  // One slot per word that can still be in flight when L0 stalls.
  localparam int SKID_DEPTH  = XMEM_RD_LAT + 1;

  function automatic logic is_streaming(input state_e s);
    return (s == S_RUN) || (s == S_DRAIN);
  endfunction

endpackage

// File: rtl/act_stream_ctrl_skid_fifo.sv
// stream_skid_fifo: 2-entry FIFO that absorbs SRAM words arriving while L0 is full.
module stream_skid_fifo #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        count_o,
  output logic              empty_o,
  output logic              full_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic [1:0]        count_d;

  // NOTE: the data array has no reset; contents are only observable through
  // count_q, which is reset, so clearing the storage would buy nothing.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);

  a_no_overflow:  assert property (@(posedge clk) disable iff (reset) !(push_i && full_o));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(pop_i && empty_o));

endmodule

// File: rtl/act_stream_ctrl.sv
// Activation streamer: strided SRAM burst reads forwarded to corelet L0 with skid buffering.
// Optional stall counter enabled by defining STREAM_PERF_EN.
module act_stream_ctrl
  import act_stream_ctrl_pkg::*;
#(
  parameter  int BW     = 4,
  parameter  int ROW    = 8,
  parameter  int ADDR_W = 11,
  parameter  int LEN_W  = 12,
  localparam int DATA_W = BW * ROW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              CEN_xmem,
  output logic              WEN_xmem,
  output logic [ADDR_W-1:0] A_xmem,
  input  logic [DATA_W-1:0] Q_act,
  input  logic              l0_full,
  output logic              l0_wr,
  output logic [DATA_W-1:0] l0_in,
  output logic [31:0]       stall_cycles
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic              rd_pend_q;

  logic              issue;
  logic              accept_start;
  logic              skid_push, skid_pop, skid_empty, skid_full;
  logic [1:0]        skid_count;
  logic [DATA_W-1:0] skid_head;
  logic              direct_wr;

  assign accept_start = (state_q == S_IDLE) && start;

  // Reads are throttled so every word in flight already owns a skid slot.
  assign issue = (state_q == S_RUN) && (issued_q < len_q) && !l0_full &&
                 ((3'(skid_count) + 3'(rd_pend_q)) < 3'(SKID_DEPTH));

  assign CEN_xmem = ~issue;
  assign WEN_xmem = 1'b1;
  assign A_xmem   = issue ? cur_addr_q : '0;

  assign skid_pop  = !skid_empty && !l0_full;
  assign direct_wr = skid_empty && rd_pend_q && !l0_full;
  assign skid_push = rd_pend_q && !direct_wr;

  assign l0_wr = skid_pop || direct_wr;
  assign l0_in = skid_pop  ? skid_head :
                 direct_wr ? Q_act     : '0;

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    stride_d   = stride_q;
    len_d      = len_q;
    issued_d   = issued_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_addr_d = base_addr;
          stride_d   = stride;
          len_d      = length;
          issued_d   = '0;
          state_d    = (length == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          cur_addr_d = cur_addr_q + stride_q;
          issued_d   = issued_q + 1'b1;
        end
        if (issued_q == len_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!rd_pend_q && skid_empty) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cur_addr_q <= '0;
      stride_q   <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      rd_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      stride_q   <= stride_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      rd_pend_q  <= issue;
    end
  end

  stream_skid_fifo #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .data_i  (Q_act),
    .data_o  (skid_head),
    .count_o (skid_count),
    .empty_o (skid_empty),
    .full_o  (skid_full)
  );

`ifdef STREAM_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (accept_start) begin
      stall_d = '0;
    end else if (is_streaming(state_q) && l0_full && (!skid_empty || rd_pend_q) &&
                 (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
